// File: rtl/angle_pkg.sv
// ---------------------------------------------------------------------------
// angle_pkg
// Shared types and constants for the encoder angle tracker.
//   tracker_state_t : FSM states of the conversion/handshake sequencer
//   step_dir_t      : classification of one {A,B} sample-to-sample transition
//   gray_step()     : decodes a previous/current {A,B} pair into a step_dir_t
// ---------------------------------------------------------------------------
package angle_pkg;

    localparam int DEG_PER_REV = 360;
    localparam int ANGLE_W     = 12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        CMP,
        SEND
    } tracker_state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN,
        STEP_ILLEGAL
    } step_dir_t;

    // Forward Gray order of {A,B} is 00 -> 01 -> 11 -> 10 -> 00.
    // A change of both bits in one sample has no defined direction.
    function automatic step_dir_t gray_step(input logic [1:0] prev_ab,
                                           input logic [1:0] curr_ab);
        step_dir_t dir;
        dir = STEP_ILLEGAL;
        if (prev_ab == curr_ab) begin
            dir = STEP_NONE;
        end else begin
            case ({prev_ab, curr_ab})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dir = STEP_UP;
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dir = STEP_DN;
                default:                                dir = STEP_ILLEGAL;
            endcase
        end
        return dir;
    endfunction

endpackage

// File: rtl/quad_step_decoder.sv
// ---------------------------------------------------------------------------
// quad_step_decoder
// Brings the asynchronous encoder channels into the clk domain, optionally
// debounces them, and decodes each sample-to-sample change into a step.
// Optional feature macro: ENC_GLITCH_FILTER_EN (per-channel stability filter
// of FILTER_CYCLES consecutive equal samples).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enc_a, enc_b      : raw encoder channels (asynchronous)
//   step_up, step_dn  : one-cycle pulses, one per legal Gray step
//   illegal           : one-cycle pulse when both channels change at once
// ---------------------------------------------------------------------------
module quad_step_decoder
    import angle_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic step_up,
    output logic step_dn,
    output logic illegal
);

    // Bit 1 carries channel A, bit 0 channel B throughout.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] clean_ab;
    logic [1:0] prev_q;
    step_dir_t  dir;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
        end
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]          filt_q, filt_d;
    logic [1:0][FCW-1:0] stab_q, stab_d;

    // A channel's filtered value follows the synced value only once the
    // new value has been seen on FILTER_CYCLES consecutive samples; any
    // return to the old value restarts the count.
    always_comb begin
        filt_d = filt_q;
        stab_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (stab_q[i] == FCW'(FILTER_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            stab_q <= '0;
        end else begin
            filt_q <= filt_d;
            stab_q <= stab_d;
        end
    end

    assign clean_ab = filt_q;
`else
    assign clean_ab = sync2_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= clean_ab;
        end
    end

    // prev_q always follows clean_ab, so each change yields exactly one pulse.
    assign dir     = gray_step(prev_q, clean_ab);
    assign step_up = (dir == STEP_UP);
    assign step_dn = (dir == STEP_DN);
    assign illegal = (dir == STEP_ILLEGAL);

endmodule

// File: rtl/encoder_angle_tracker.sv
// ---------------------------------------------------------------------------
// encoder_angle_tracker
// Tracks a quadrature encoder position, converts it to whole degrees with a
// restoring divider, and hands each changed angle to the LCD controller.
// Optional feature macro: ENC_GLITCH_FILTER_EN (input glitch filter).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   enc_a/enc_b : raw quadrature channels (asynchronous)
//   zero_req    : synchronous pulse, forces the position count to 0
//   disp_busy   : display busy; a transfer happens when write && !disp_busy
//   angle       : degrees 0..359, held stable while write is high
//   write       : angle valid, held until accepted
//   quad_err    : sticky illegal-transition flag, cleared only by reset
// ---------------------------------------------------------------------------
module encoder_angle_tracker
    import angle_pkg::*;
#(
    parameter int COUNTS_PER_REV = 2048,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               zero_req,
    input  logic               disp_busy,
    output logic [ANGLE_W-1:0] angle,
    output logic               write,
    output logic               quad_err
);

    localparam int CW  = $clog2(COUNTS_PER_REV);
    localparam int PW  = CW + 9;               // count * 360 fits here
    localparam int RW  = CW + 1;               // partial remainder width
    localparam int BCW = $clog2(PW);

    localparam logic [CW-1:0] CNT_MAX = CW'(COUNTS_PER_REV - 1);
    localparam logic [RW:0]   DIVISOR = (RW + 1)'(COUNTS_PER_REV);

    logic step_up, step_dn, illegal;

    quad_step_decoder #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_decoder (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .step_up (step_up),
        .step_dn (step_dn),
        .illegal (illegal)
    );

    tracker_state_t     state_q,     state_d;
    logic [CW-1:0]      count_q,     count_d;
    logic               pending_q,   pending_d;
    logic               quad_err_q,  quad_err_d;
    logic [PW-1:0]      dvd_q,       dvd_d;       // dividend in, quotient out
    logic [RW-1:0]      rem_q,       rem_d;
    logic [BCW-1:0]     bit_q,       bit_d;
    logic [ANGLE_W-1:0] angle_q,     angle_d;
    logic [ANGLE_W-1:0] last_sent_q, last_sent_d;
    logic [RW:0]        rem_shift;

    // Position counter. It runs independently of the FSM so no step is ever
    // lost while a conversion or a stalled transfer is in progress.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d    = count_q;
        pending_d  = pending_q;
        quad_err_d = quad_err_q | illegal;
        if (zero_req) begin
            count_d   = '0;
            pending_d = 1'b1;
        end else if (step_up) begin
            count_d   = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
            pending_d = 1'b1;
        end else if (step_dn) begin
            count_d   = (count_q == '0) ? CNT_MAX : count_q - 1'b1;
            pending_d = 1'b1;
        end else if (state_q == LOAD) begin
            // A step landing in the LOAD cycle keeps pending set, forcing
            // a recompute after this conversion.
            pending_d = 1'b0;
        end
    end

    // One restoring-division iteration: shift in the next dividend bit and
    // subtract the divisor when it fits.
    assign rem_shift = {rem_q, dvd_q[PW-1]};

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        bit_d       = bit_q;
        angle_d     = angle_q;
        last_sent_d = last_sent_q;
        case (state_q)
            IDLE: begin
                if (pending_q) state_d = LOAD;
            end
            LOAD: begin
                dvd_d   = PW'(count_q) * PW'(DEG_PER_REV);
                rem_d   = '0;
                bit_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                if (rem_shift >= DIVISOR) begin
                    rem_d = RW'(rem_shift - DIVISOR);
                    dvd_d = {dvd_q[PW-2:0], 1'b1};
                end else begin
                    rem_d = RW'(rem_shift);
                    dvd_d = {dvd_q[PW-2:0], 1'b0};
                end
                if (bit_q == BCW'(PW - 1)) begin
                    state_d = CMP;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            CMP: begin
                // Quotient is below 360, so the low ANGLE_W bits hold it all.
                if (dvd_q[ANGLE_W-1:0] == last_sent_q) begin
                    state_d = IDLE;
                end else begin
                    angle_d = dvd_q[ANGLE_W-1:0];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!disp_busy) begin
                    last_sent_d = angle_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pending_q   <= 1'b0;
            quad_err_q  <= 1'b0;
            dvd_q       <= '0;
            rem_q       <= '0;
            bit_q       <= '0;
            angle_q     <= '0;
            last_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            quad_err_q  <= quad_err_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            bit_q       <= bit_d;
            angle_q     <= angle_d;
            last_sent_q <= last_sent_d;
        end
    end

    assign angle    = angle_q;
    assign write    = (state_q == SEND);
    assign quad_err = quad_err_q;

endmodule
